// File: rtl/perf_counter_delta_streamer_pkg.sv
// Shared constants, helper functions and state encoding for the
// performance-counter delta streamer.
package perf_stream_pkg;

  // Streamer FSM states.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  // Number of whole counter lanes that fit in one stream beat.
  function automatic int calc_lanes(input int data_width, input int counter_width);
    return data_width / counter_width;
  endfunction

  // Beats needed to carry every counter, rounded up.
  function automatic int calc_beats(input int num_counters, input int lanes);
    return (num_counters + lanes - 1) / lanes;
  endfunction

  // Width of the beat index register, never narrower than one bit.
  function automatic int calc_beat_idx_w(input int num_beats);
    return (num_beats > 1) ? $clog2(num_beats) : 1;
  endfunction

endpackage

// File: rtl/perf_counter_delta_streamer_if.sv
// AXI-Stream master link carrying the packed counter deltas.
interface perf_counter_delta_streamer_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0] m_tdata;
  logic                  m_tvalid;
  logic                  m_tready;
  logic                  m_tlast;

  modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
  modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);
endinterface

// File: rtl/perf_counter_delta_streamer_delta_bank.sv
// Previous-snapshot and delta register arrays. On a capture strobe each
// delta becomes the modular increment since the last capture.
module perf_delta_bank #(
  parameter int NUM_COUNTERS  = 115,
  parameter int COUNTER_WIDTH = 7
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  capture,
  input  logic [NUM_COUNTERS*COUNTER_WIDTH-1:0] counters_flat,
  output logic [NUM_COUNTERS*COUNTER_WIDTH-1:0] delta_flat
);

  logic [COUNTER_WIDTH-1:0] prev_r  [NUM_COUNTERS];
  logic [COUNTER_WIDTH-1:0] delta_r [NUM_COUNTERS];

  // Capture counters and form W-bit wrapping deltas; hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        prev_r[i]  <= '0;
        delta_r[i] <= '0;
      end
    end else if (capture) begin
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        delta_r[i] <= counters_flat[i*COUNTER_WIDTH +: COUNTER_WIDTH] - prev_r[i];
        prev_r[i]  <= counters_flat[i*COUNTER_WIDTH +: COUNTER_WIDTH];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_COUNTERS; gi++) begin : g_flat
    assign delta_flat[gi*COUNTER_WIDTH +: COUNTER_WIDTH] = delta_r[gi];
  end

endmodule

// File: rtl/perf_counter_delta_streamer.sv
// Snapshot consumer for the performance counter array: captures all counters
// on request and streams their deltas as one AXI-Stream packet.
module perf_counter_delta_streamer
  import perf_stream_pkg::*;
#(
  parameter int NUM_COUNTERS   = 115,
  parameter int COUNTER_WIDTH  = 7,
  parameter int DATA_WIDTH     = 64,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_COUNTERS*COUNTER_WIDTH-1:0] counters_flat,
  input  logic                                  snapshot_req,
  perf_counter_delta_streamer_if.master         axis,
  output logic                                  busy,
  output logic [DROP_CNT_WIDTH-1:0]             dropped_count
);

  localparam int LANES     = calc_lanes(DATA_WIDTH, COUNTER_WIDTH);
  localparam int NUM_BEATS = calc_beats(NUM_COUNTERS, LANES);
  localparam int BIW       = calc_beat_idx_w(NUM_BEATS);

  localparam logic [BIW-1:0] LAST_BEAT = BIW'(NUM_BEATS - 1);
  localparam logic [0:0]     ST_IDLE   = IDLE;
  localparam logic [0:0]     ST_STREAM = STREAM;

  logic [0:0]                            state_r;
  logic [BIW-1:0]                        beat_r;
  logic [DROP_CNT_WIDTH-1:0]             drop_r;
  logic                                  stream_s;
  logic                                  last_s;
  logic                                  capture_s;
  logic [NUM_COUNTERS*COUNTER_WIDTH-1:0] delta_flat_s;
  logic [DATA_WIDTH-1:0]                 tdata_s;

  assign stream_s  = (state_r == ST_STREAM);
  assign last_s    = stream_s && (beat_r == LAST_BEAT);
  assign capture_s = (state_r == ST_IDLE) && snapshot_req;

  perf_delta_bank #(
    .NUM_COUNTERS  (NUM_COUNTERS),
    .COUNTER_WIDTH (COUNTER_WIDTH)
  ) u_bank (
    .clk           (clk),
    .rst_n         (rst_n),
    .capture       (capture_s),
    .counters_flat (counters_flat),
    .delta_flat    (delta_flat_s)
  );

  // Packet FSM: start on an accepted request, step beats on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      beat_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (snapshot_req) begin
            state_r <= ST_STREAM;
            beat_r  <= '0;
          end
        end
        ST_STREAM: begin
          if (axis.m_tready) begin
            if (beat_r == LAST_BEAT) begin
              state_r <= ST_IDLE;
              beat_r  <= '0;
            end else begin
              beat_r <= beat_r + BIW'(1);
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          beat_r  <= '0;
        end
      endcase
    end
  end

  // Saturating count of requests that arrive while a packet is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_r <= '0;
    end else if (stream_s && snapshot_req && (drop_r != '1)) begin
      drop_r <= drop_r + DROP_CNT_WIDTH'(1);
    end
  end

  // Select the lanes of the current beat; unused lanes and pad bits are zero.
  always_comb begin
    int idx;
    idx     = 0;
    tdata_s = '0;
    if (stream_s) begin
      for (int l = 0; l < LANES; l++) begin
        idx = int'(beat_r) * LANES + l;
        if (idx < NUM_COUNTERS) begin
          tdata_s[l*COUNTER_WIDTH +: COUNTER_WIDTH] =
            delta_flat_s[idx*COUNTER_WIDTH +: COUNTER_WIDTH];
        end else begin
          tdata_s[l*COUNTER_WIDTH +: COUNTER_WIDTH] = '0;
        end
      end
    end else begin
      tdata_s = '0;
    end
  end

  // All stream outputs depend only on registered state, never on m_tready.
  assign axis.m_tdata   = tdata_s;
  assign axis.m_tvalid  = stream_s;
  assign axis.m_tlast   = last_s;
  assign busy           = stream_s;
  assign dropped_count  = drop_r;

endmodule

// File: tb/tb_perf_counter_delta_streamer.sv
// Scoreboard bench for perf_counter_delta_streamer at default parameters.
module tb_perf_counter_delta_streamer;

  localparam int N  = 115;
  localparam int W  = 7;
  localparam int DW = 64;
  localparam int NB = 13;
  localparam int LN = 9;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             snapshot_req = 1'b0;
  logic [N*W-1:0]   counters_flat;
  logic             busy;
  logic [15:0]      dropped_count;
  logic [W-1:0]     cnt [N];

  perf_counter_delta_streamer_if #(.DATA_WIDTH(DW)) axis ();

  perf_counter_delta_streamer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .counters_flat (counters_flat),
    .snapshot_req  (snapshot_req),
    .axis          (axis.master),
    .busy          (busy),
    .dropped_count (dropped_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) counters_flat[i*W +: W] = cnt[i];
  end

  int            total = 0;
  int            bad = 0;
  beat_t         sb [$];
  logic [W-1:0]  prev_m [N];
  logic [W-1:0]  dlt_m [N];
  logic [DW-1:0] got [16];
  int            hs_cnt = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pack_beat(input int b);
    logic [DW-1:0] r;
    r = '0;
    for (int l = 0; l < LN; l++) begin
      if (b * LN + l < N) r[l*W +: W] = dlt_m[b*LN + l];
    end
    return r;
  endfunction

  // Model an accepted snapshot and queue the packet it must produce.
  task automatic push_packet();
    beat_t e;
    for (int i = 0; i < N; i++) begin
      dlt_m[i]  = cnt[i] - prev_m[i];
      prev_m[i] = cnt[i];
    end
    for (int b = 0; b < NB; b++) begin
      e.data = pack_beat(b);
      e.last = (b == NB - 1);
      sb.push_back(e);
    end
  endtask

  // Called at posedge+1 while idle: one-cycle request, first beat next cycle.
  task automatic snap();
    snapshot_req = 1'b1;
    push_packet();
    @(posedge clk); #1;
    snapshot_req = 1'b0;
    chk("first_valid_latency", axis.m_tvalid, 1);
    chk("busy_on_start", busy, 1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200 && busy; k++) begin
      @(posedge clk); #1;
    end
    chk("drain_timeout", busy, 0);
  endtask

  // Monitor: compare every handshaked beat against the scoreboard.
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      hs_cnt = 0;
    end else if (axis.m_tvalid && axis.m_tready) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("beat_data", axis.m_tdata, e.data);
        chk("beat_last", axis.m_tlast, e.last);
      end
      if (hs_cnt < 16) got[hs_cnt] = axis.m_tdata;
      hs_cnt++;
      if (axis.m_tlast) begin
        chk("pkt_len", hs_cnt, NB);
        hs_cnt = 0;
      end
    end
  end

  initial begin
    logic [DW-1:0] exp_b3;
    for (int i = 0; i < N; i++) begin
      cnt[i]    = '0;
      prev_m[i] = '0;
      dlt_m[i]  = '0;
    end
    axis.m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", axis.m_tvalid, 0);
    chk("rst_tlast", axis.m_tlast, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tdata", axis.m_tdata, 0);
    chk("rst_dropped", dropped_count, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic packet: 13 back-to-back beats.
    cnt[0] = 7'd5; cnt[114] = 7'd3;
    snap();
    repeat (12) @(posedge clk);
    #1;
    chk("tlast_on_beat12", axis.m_tlast, 1);
    chk("busy_on_beat12", busy, 1);
    @(posedge clk); #1;
    chk("busy_after_last", busy, 0);
    chk("tvalid_after_last", axis.m_tvalid, 0);
    chk("basic_b0_lane0", got[0][6:0], 7'd5);
    chk("basic_b12_lane6", got[12][48:42], 7'd3);
    chk("basic_b12_pad", got[12][63:49], 15'd0);

    // Wrap-around of a 7-bit delta.
    cnt[1] = 7'd120;
    snap(); wait_idle();
    cnt[1] = 7'd4;
    snap(); wait_idle();
    chk("wrap_b0_lane1", got[0][13:7], 7'd12);

    // Backpressure on beat 3.
    for (int i = 27; i < 36; i++) cnt[i] = 7'(i * 3);
    snap();
    repeat (3) @(posedge clk);
    #1;
    axis.m_tready = 1'b0;
    exp_b3 = pack_beat(3);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_tvalid", axis.m_tvalid, 1);
      chk("bp_tdata", axis.m_tdata, exp_b3);
      chk("bp_tlast", axis.m_tlast, 0);
    end
    axis.m_tready = 1'b1;
    wait_idle();

    // Request during beat 5 is dropped.
    cnt[7] = 7'd40;
    snap();
    repeat (5) @(posedge clk);
    #1;
    cnt[7] = 7'd77;
    snapshot_req = 1'b1;
    @(posedge clk); #1;
    snapshot_req = 1'b0;
    chk("drop_count", dropped_count, 1);
    wait_idle();
    snap(); wait_idle();
    chk("drop_rel_first", got[0][55:49], 7'd37);

    // Asynchronous reset during beat 6.
    snap();
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_tvalid", axis.m_tvalid, 0);
    chk("async_busy", busy, 0);
    sb.delete();
    for (int i = 0; i < N; i++) prev_m[i] = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("async_dropped", dropped_count, 0);
    cnt[2] = 7'd9;
    snap(); wait_idle();
    chk("post_rst_lane2", got[0][20:14], 7'd9);

    // Back-to-back: coincident request dropped, next-cycle request accepted.
    snap();
    repeat (12) @(posedge clk);
    #1;
    snapshot_req = 1'b1;
    @(posedge clk); #1;
    chk("b2b_idle_gap", axis.m_tvalid, 0);
    chk("b2b_drop", dropped_count, 1);
    cnt[3] = 7'd11;
    snap();
    wait_idle();
    chk("b2b_lane3", got[0][27:21], 7'd11);
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
